// File: rtl/alu_driver.sv
// alu_driver: issues commands to a fixed-latency ALU, tracks them through a
// three-stage valid/opcode pipe and queues the results in a show-ahead FIFO.
// Command acceptance is credit based, so the FIFO can never overflow.
module alu_driver #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_in0,
  input  logic [WIDTH-1:0] cmd_in1,
  input  logic [2:0]       cmd_op,
  output logic [WIDTH-1:0] alu_in0,
  output logic [WIDTH-1:0] alu_in1,
  output logic [2:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_overflow,
  output logic [1:0]       inflight
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Command drive registers towards the ALU
  logic [WIDTH-1:0] alu_in0_q, alu_in1_q;
  logic [2:0]       alu_opcode_q;

  // Tracking pipe: stage 0 is set on the accept edge, stage 2 holds the
  // command whose result is on alu_out during the current cycle.
  logic [2:0] pipe_vld_q, pipe_vld_d;
  logic [2:0] pipe_op_q [3];
  logic [2:0] pipe_op_d [3];

  // Response FIFO state
  logic [WIDTH:0]   mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             ready_q, ready_d;

  logic             accept, push, pop, push_ovf;
  logic [1:0]       inflight_d;
  logic [WIDTH:0]   head_word;

  assign accept   = cmd_valid & ready_q;
  assign push     = pipe_vld_q[2];
  assign pop      = (count_q != '0) & rsp_ready;
  // Compare opcodes (101/110/111) never report overflow
  assign push_ovf = alu_overflow & (pipe_op_q[2] < 3'd5);

  // Shift the tracking pipe; stage 0 samples the accept
  always_comb begin
    pipe_vld_d   = {pipe_vld_q[1:0], accept};
    pipe_op_d[0] = cmd_op;
  end

  generate
    for (genvar gi = 1; gi < 3; gi++) begin : g_pipe_op
      assign pipe_op_d[gi] = pipe_op_q[gi-1];
    end
  endgenerate

  // Next FIFO occupancy and the credit check that gates the next accept;
  // cmd_ready is registered so it depends on no same-cycle input.
  always_comb begin
    count_d    = count_q + CW'(push) - CW'(pop);
    inflight_d = {1'b0, pipe_vld_d[0]} + {1'b0, pipe_vld_d[1]} + {1'b0, pipe_vld_d[2]};
    ready_d    = ({1'b0, count_d} + (CW+1)'(inflight_d)) < (CW+1)'(DEPTH);
  end

  // Control state: pipe, pointers, occupancy, credit and ALU drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q   <= '0;
      for (int i = 0; i < 3; i++) pipe_op_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ready_q      <= 1'b0;
      alu_in0_q    <= '0;
      alu_in1_q    <= '0;
      alu_opcode_q <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      for (int i = 0; i < 3; i++) pipe_op_q[i] <= pipe_op_d[i];
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ready_q <= ready_d;
      if (accept) begin
        alu_in0_q    <= cmd_in0;
        alu_in1_q    <= cmd_in1;
        alu_opcode_q <= cmd_op;
      end
    end
  end

  // FIFO storage; contents need no reset because occupancy gates the read side
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_ovf, alu_out};
  end

  assign head_word    = mem_q[rd_ptr_q];
  assign rsp_valid    = (count_q != '0);
  assign rsp_data     = head_word[WIDTH-1:0];
  assign rsp_overflow = head_word[WIDTH];
  assign cmd_ready    = ready_q;
  assign alu_in0      = alu_in0_q;
  assign alu_in1      = alu_in1_q;
  assign alu_opcode   = alu_opcode_q;
  assign inflight     = {1'b0, pipe_vld_q[0]} + {1'b0, pipe_vld_q[1]} + {1'b0, pipe_vld_q[2]};

endmodule

// File: tb/tb_alu_driver.sv
// Bench for alu_driver: a small fixed-latency ALU model, a transaction-level
// reference queue, a per-cycle compare process, directed scenarios and a
// randomized phase.
module tb_alu_driver;
  localparam int W = 16;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0, cmd_ready;
  logic [W-1:0] cmd_in0 = '0, cmd_in1 = '0;
  logic [2:0]   cmd_op = '0;
  logic [W-1:0] alu_in0, alu_in1;
  logic [2:0]   alu_opcode;
  logic [W-1:0] alu_out = '0;
  logic         alu_overflow = 1'b0;
  logic         rsp_valid, rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic         rsp_overflow;
  logic [1:0]   inflight;

  int vectors = 0;
  int errs    = 0;

  alu_driver #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_in0(cmd_in0), .cmd_in1(cmd_in1), .cmd_op(cmd_op),
    .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_overflow(rsp_overflow),
    .inflight(inflight)
  );

  always #5 clk = ~clk;

  // ALU semantics: returns {overflow, result}
  function automatic logic [W:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         o;
    r = '0;
    o = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; o = s[W]; end
      3'd1: begin r = a - b; o = (a < b); end
      3'd2: begin r = a & b; o = r[0] ^ r[W-1]; end
      3'd3: begin r = a | b; o = r[0] ^ r[W-1]; end
      3'd4: begin r = a ^ b; o = r[0] ^ r[W-1]; end
      3'd5: begin r = (a > b)  ? W'(1) : W'(0); o = 1'b1; end
      3'd6: begin r = (a == b) ? W'(1) : W'(0); o = 1'b1; end
      default: begin r = (a < b) ? W'(1) : W'(0); o = 1'b1; end
    endcase
    return {o, r};
  endfunction

  // Two-cycle ALU: capture inputs one edge after they change, result one edge later
  logic [W-1:0] cap_a = '0, cap_b = '0;
  logic [2:0]   cap_op = '0;
  always @(posedge clk) begin
    cap_a  <= alu_in0;
    cap_b  <= alu_in1;
    cap_op <= alu_opcode;
    {alu_overflow, alu_out} <= alu_f(cap_op, cap_a, cap_b);
  end

  // Reference model: every accepted command awaits its response in order
  typedef struct { logic [W:0] v; int t; } ent_t;
  ent_t         q[$];
  int           cyc = 0;
  int           n_acc = 0;
  bit           armed = 0;
  logic [W-1:0] last_a = '0, last_b = '0;
  logic [2:0]   last_op = '0;
  logic [W:0]   got[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      armed   = 0;
      cyc     = 0;
      last_a  = '0;
      last_b  = '0;
      last_op = '0;
    end else begin
      ent_t e;
      logic [W:0] r;
      cyc++;
      armed = 1;
      if (rsp_valid && rsp_ready) begin
        got.push_back({rsp_overflow, rsp_data});
        if (q.size() > 0) void'(q.pop_front());
      end
      if (cmd_valid && cmd_ready) begin
        r = alu_f(cmd_op, cmd_in0, cmd_in1);
        if (cmd_op >= 3'd5) r[W] = 1'b0;
        e.v = r;
        e.t = cyc;
        q.push_back(e);
        n_acc++;
        last_a  = cmd_in0;
        last_b  = cmd_in1;
        last_op = cmd_op;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the reference model
  always @(negedge clk) begin
    if (armed && !rst) begin
      bit exp_v;
      int exp_if;
      exp_v  = (q.size() > 0) && (cyc - q[0].t >= 3);
      exp_if = 0;
      foreach (q[i]) if (cyc - q[i].t < 3) exp_if++;
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (exp_v && rsp_valid) chk("rsp_payload", 32'({rsp_overflow, rsp_data}), 32'(q[0].v));
      chk("cmd_ready", 32'(cmd_ready), 32'(q.size() < D));
      chk("inflight", 32'(inflight), 32'(exp_if));
      chk("alu_drive", {alu_opcode, alu_in1[12:0], alu_in0}, {last_op, last_b[12:0], last_a});
    end
  end

  // Present a command and hold it until accepted; returns 1ns after the accept edge
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    bit done;
    done = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_in0 = a;
    cmd_in1 = b;
    for (int k = 0; k < 50 && !done; k++) begin
      ok = cmd_ready;
      @(posedge clk);
      #1;
      if (ok) done = 1;
    end
    cmd_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_inflight",  32'(inflight),  32'd0);
    #3 rst = 1'b0;
    cycles(1);
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // ADD 3+5 with exact 3-cycle latency
    rsp_ready = 1'b1;
    got.delete();
    send(3'b000, 16'h0003, 16'h0005);
    chk("add_inflight", 32'(inflight), 32'd1);
    chk("add_lat0", 32'(rsp_valid), 32'd0);
    cycles(1); chk("add_lat1", 32'(rsp_valid), 32'd0);
    cycles(1); chk("add_lat2", 32'(rsp_valid), 32'd0);
    cycles(1); chk("add_lat3", 32'(rsp_valid), 32'd1);
    chk("add_data", 32'(rsp_data), 32'h0008);
    chk("add_ovf",  32'(rsp_overflow), 32'd0);
    cycles(4);

    // Overflow, then compare op whose ALU overflow must be masked
    got.delete();
    send(3'b000, 16'hFFFF, 16'h0001);
    send(3'b101, 16'h0005, 16'h0003);
    cycles(8);
    chk("ovf_count", 32'(got.size()), 32'd2);
    if (got.size() >= 2) begin
      chk("ovf_add", 32'(got[0]), 32'h1_0000);
      chk("ovf_cmp", 32'(got[1]), 32'h0_0001);
    end

    // Back-pressure: exactly DEPTH accepts, then one pop frees one credit
    got.delete();
    rsp_ready = 1'b0;
    base = n_acc;
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_in0 = 16'd1; cmd_in1 = 16'd2;
    cycles(20);
    chk("bp_accepts", 32'(n_acc - base), 32'd8);
    chk("bp_ready",   32'(cmd_ready), 32'd0);
    chk("bp_inflight", 32'(inflight), 32'd0);
    rsp_ready = 1'b1;
    cycles(1);
    rsp_ready = 1'b0;
    chk("bp_ready_after_pop", 32'(cmd_ready), 32'd1);
    cycles(1);
    chk("bp_accepts2", 32'(n_acc - base), 32'd9);
    chk("bp_ready_full", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    cycles(20);
    chk("bp_drained", 32'(got.size()), 32'd9);

    // Sustained throughput: 16 back-to-back SUBs
    got.delete();
    for (int i = 0; i < 16; i++) begin
      cmd_valid = 1'b1; cmd_op = 3'b001; cmd_in0 = W'(i + 10); cmd_in1 = W'(i);
      chk("b2b_ready", 32'(cmd_ready), 32'd1);
      cycles(1);
    end
    cmd_valid = 1'b0;
    cycles(8);
    chk("b2b_count", 32'(got.size()), 32'd16);
    foreach (got[i]) chk("b2b_data", 32'(got[i]), 32'h0_000A);

    // Reset mid-flight discards everything outstanding
    got.delete();
    rsp_ready = 1'b0;
    send(3'b000, 16'd1, 16'd2);
    send(3'b000, 16'd3, 16'd4);
    send(3'b000, 16'd5, 16'd6);
    cycles(1);
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("midrst_valid",    32'(rsp_valid), 32'd0);
    chk("midrst_ready",    32'(cmd_ready), 32'd0);
    chk("midrst_inflight", 32'(inflight),  32'd0);
    chk("midrst_alu_in0",  32'(alu_in0),   32'd0);
    #9 rst = 1'b0;
    rsp_ready = 1'b1;
    cycles(1);
    chk("ready_after_rst2", 32'(cmd_ready), 32'd1);
    cycles(6);
    chk("no_stale", 32'(got.size()), 32'd0);
    send(3'b000, 16'd1, 16'd1);
    cycles(6);
    chk("post_rst_count", 32'(got.size()), 32'd1);
    if (got.size() >= 1) chk("post_rst_data", 32'(got[0]), 32'h0_0002);

    // Randomized traffic with random back-pressure
    for (int k = 0; k < 3000; k++) begin
      cmd_valid = ($urandom_range(3) != 0);
      cmd_op    = 3'($urandom_range(7));
      cmd_in0   = ($urandom_range(7) == 0) ? 16'hFFFF : W'($urandom);
      cmd_in1   = ($urandom_range(7) == 0) ? cmd_in0  : W'($urandom);
      rsp_ready = ($urandom_range(2) != 0);
      cycles(1);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    cycles(20);
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/alu_driver.md
ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits.
REQ-002 SHALL have parameter DEPTH, default 8: response FIFO depth; power of 2, 4..64.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports cmd_valid input 1, cmd_ready output 1: command handshake.
REQ-006 SHALL have ports cmd_in0, cmd_in1 input WIDTH, cmd_op input 3: command operands and opcode.
REQ-007 SHALL have ports alu_in0, alu_in1 output WIDTH, alu_opcode output 3: registered drive to the ALU.
REQ-008 SHALL have ports alu_out input WIDTH, alu_overflow input 1: ALU result.
REQ-009 SHALL have ports rsp_valid output 1, rsp_ready input 1: response handshake.
REQ-010 SHALL have ports rsp_data output WIDTH, rsp_overflow output 1: response payload.
REQ-011 SHALL have port inflight output 2: count of issued commands not yet in the FIFO.

Function
REQ-012 SHALL accept a command at a rising edge where cmd_valid and cmd_ready are both 1.
REQ-013 SHALL load cmd_in0/cmd_in1/cmd_op into alu_in0/alu_in1/alu_opcode on the accept edge E; these SHALL hold their value when no command is accepted.
REQ-014 SHALL treat ALU latency as fixed: inputs driven after E are captured by the ALU at E+1; alu_out/alu_overflow are valid after E+2.
REQ-015 SHALL track issued commands in a 3-stage valid/opcode shift pipe (stages set at E, E+1, E+2); inflight = number of set stages.
REQ-016 SHALL write {alu_out, overflow} into the FIFO at edge E+3; rsp_valid SHALL be 1 in the cycle after E+3 when the FIFO was empty (accept-to-rsp_valid latency = 3 cycles).
REQ-017 SHALL force the stored overflow to 0 when the tracked opcode is 3'b101, 3'b110 or 3'b111 (compare ops), else pass alu_overflow.
REQ-018 SHALL use a show-ahead FIFO: rsp_data/rsp_overflow SHALL present the oldest entry whenever rsp_valid=1; pop on edge with rsp_valid and rsp_ready both 1.
REQ-019 SHALL deliver responses in command order; no reordering, no drop, no duplication.
REQ-020 SHALL drive cmd_ready = 1 iff (fifo_count + inflight) < DEPTH, computed from registered state only (no combinational path from rsp_ready or cmd_valid).
REQ-021 SHALL, on simultaneous FIFO write and pop, keep fifo_count unchanged and update both pointers.
REQ-022 SHALL wrap FIFO read/write pointers modulo DEPTH; full/empty distinguished by an extra pointer bit or explicit count.
REQ-023 SHALL never write a full FIFO; guaranteed by REQ-020 credit rule.
REQ-024 SHALL sustain one command per cycle when rsp_ready is held 1 and DEPTH >= 5.
REQ-025 SHALL leave rsp_data/rsp_overflow don't-care when rsp_valid=0.

Reset
REQ-026 SHALL, while rst=1, asynchronously clear pipe stages, FIFO pointers and count, alu_in0/alu_in1/alu_opcode to 0, rsp_valid to 0, inflight to 0, cmd_ready to 0.
REQ-027 SHALL discard all in-flight and queued results on reset mid-operation; no response emitted for them after release.
REQ-028 SHALL drive cmd_ready = 1 in the first cycle after rst deasserts.

Verification
REQ-029 ADD: op=000, in0=0x0003, in1=0x0005, rsp_ready=1 -> rsp_valid exactly 3 cycles after accept, rsp_data=0x0008, rsp_overflow=0.
REQ-030 Overflow: op=000, in0=0xFFFF, in1=0x0001 -> rsp_data=0x0000, rsp_overflow=1; then op=101, in0=5, in1=3 with alu_overflow still 1 -> rsp_data=0x0001, rsp_overflow=0.
REQ-031 Back-pressure: rsp_ready=0, cmd_valid held 1 -> exactly 8 accepts, cmd_ready=0 thereafter, inflight returns to 0; single pop -> cmd_ready=1 next cycle, one more accept.
REQ-032 Throughput/order: rsp_ready=1, 16 back-to-back SUB commands in0=i+10, in1=i -> cmd_ready never drops, 16 responses all 0x000A in order.
REQ-033 Reset mid-flight: 3 commands accepted, rst pulsed 1 cycle asynchronously mid-cycle -> rsp_valid=0 immediately, no stale responses after release, new ADD 1+1 returns 0x0002.
